// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU
// operation codes, data-processing cmd field values and datapath select codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode for data-processing instructions. Only Funct[4:0]
// (cmd and S) matter here; the immediate bit is consumed by the FSM.
module alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite
);

  logic known;

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    known      = 1'b1;
    if (ALUOp) begin
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          NoWrite    = 1'b1;
        end
        default: begin
          ALUControl = ALU_ADD;
          NoWrite    = 1'b1;
          known      = 1'b0;
        end
      endcase
      // C and V only make sense for arithmetic operations
      if (known)
        FlagW = {Funct[0], Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB))};
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle ARM datapath: sequences each instruction
// through its states and drives raw write requests plus all mux selects.
module multicycle_control_fsm
  import arm_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic       Halted
);

  state_t state;
  logic   no_write_q;
  logic   alu_op;
  logic   branch;
  logic   dec_no_write;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct[4:0]),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .NoWrite    (dec_no_write)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_FETCH;
      no_write_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b01:   state <= S_MEMADR;
            2'b00:   state <= Funct[5] ? S_EXECI : S_EXECR;
            2'b10:   state <= S_BRANCH;
            default: state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
          endcase
        end
        S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  state <= S_FETCH;
        S_EXECR:  state <= S_ALUWB;
        S_EXECI:  state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
      // Capture NoWrite while the cmd is decoded so ALUWB can suppress RegW
      if (alu_op)
        no_write_q <= dec_no_write;
    end
  end

  // Reset presents the FETCH selects with every write strobe held low
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    Halted    = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (Reset ? S_FETCH : state)
      S_FETCH: begin
        IRWrite   = ~Reset;
        NextPC    = ~Reset;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcB = SRCB_RD2;
        alu_op  = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegW      = ~no_write_q;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign PCS    = branch | (RegW & (Rd == 4'hF));
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into
// its expected per-cycle output vectors from the instruction-level timing rules.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       nextpc;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluctl;
    logic       halted;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_h;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;

  logic       a_pcs, a_regw, a_memw, a_nextpc, a_irwrite, a_adrsrc, a_alusrca, a_halted;
  logic [1:0] a_flagw, a_resultsrc, a_alusrcb, a_immsrc, a_regsrc, a_aluctl;
  logic       h_pcs, h_regw, h_memw, h_nextpc, h_irwrite, h_adrsrc, h_alusrca, h_halted;
  logic [1:0] h_flagw, h_resultsrc, h_alusrcb, h_immsrc, h_regsrc, h_aluctl;
  outs_t      obs_a, obs_h;

  int checks = 0;
  int passed = 0;
  outs_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_a (
    .CLK(clk), .Reset(rst_a), .Op(op), .Funct(funct), .Rd(rd),
    .PCS(a_pcs), .RegW(a_regw), .MemW(a_memw), .FlagW(a_flagw), .NextPC(a_nextpc),
    .IRWrite(a_irwrite), .AdrSrc(a_adrsrc), .ResultSrc(a_resultsrc), .ALUSrcA(a_alusrca),
    .ALUSrcB(a_alusrcb), .ImmSrc(a_immsrc), .RegSrc(a_regsrc), .ALUControl(a_aluctl),
    .Halted(a_halted)
  );

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .CLK(clk), .Reset(rst_h), .Op(op), .Funct(funct), .Rd(rd),
    .PCS(h_pcs), .RegW(h_regw), .MemW(h_memw), .FlagW(h_flagw), .NextPC(h_nextpc),
    .IRWrite(h_irwrite), .AdrSrc(h_adrsrc), .ResultSrc(h_resultsrc), .ALUSrcA(h_alusrca),
    .ALUSrcB(h_alusrcb), .ImmSrc(h_immsrc), .RegSrc(h_regsrc), .ALUControl(h_aluctl),
    .Halted(h_halted)
  );

  assign obs_a = {a_pcs, a_regw, a_memw, a_flagw, a_nextpc, a_irwrite, a_adrsrc, a_resultsrc,
                  a_alusrca, a_alusrcb, a_immsrc, a_regsrc, a_aluctl, a_halted};
  assign obs_h = {h_pcs, h_regw, h_memw, h_flagw, h_nextpc, h_irwrite, h_adrsrc, h_resultsrc,
                  h_alusrca, h_alusrcb, h_immsrc, h_regsrc, h_aluctl, h_halted};

  // Outputs that follow the instruction fields regardless of phase
  function automatic outs_t blank(input logic [1:0] o_op);
    outs_t o;
    o        = '0;
    o.immsrc = o_op;
    o.regsrc = {o_op == 2'b01, o_op == 2'b10};
    return o;
  endfunction

  function automatic outs_t fetch_v(input logic [1:0] o_op);
    outs_t o;
    o           = blank(o_op);
    o.irwrite   = 1'b1;
    o.nextpc    = 1'b1;
    o.alusrca   = 1'b1;
    o.alusrcb   = 2'b10;
    o.resultsrc = 2'b10;
    return o;
  endfunction

  function automatic outs_t reset_v(input logic [1:0] o_op);
    outs_t o;
    o         = fetch_v(o_op);
    o.irwrite = 1'b0;
    o.nextpc  = 1'b0;
    return o;
  endfunction

  function automatic outs_t decode_v(input logic [1:0] o_op);
    outs_t o;
    o           = blank(o_op);
    o.alusrca   = 1'b1;
    o.alusrcb   = 2'b10;
    o.resultsrc = 2'b10;
    return o;
  endfunction

  // Expected cycle-by-cycle outputs of one whole instruction on the ILLEGAL_HALT=0 unit
  task automatic build(input logic [1:0] b_op, input logic [5:0] b_funct, input logic [3:0] b_rd);
    outs_t o;
    logic [1:0] ctl;
    bit known, wr;
    exp_q.delete();
    exp_q.push_back(fetch_v(b_op));
    exp_q.push_back(decode_v(b_op));
    case (b_op)
      2'b01: begin
        o = blank(b_op); o.alusrcb = 2'b01;
        exp_q.push_back(o);
        if (b_funct[0]) begin
          o = blank(b_op); o.adrsrc = 1'b1;
          exp_q.push_back(o);
          o = blank(b_op); o.resultsrc = 2'b01; o.regw = 1'b1; o.pcs = (b_rd == 4'd15);
          exp_q.push_back(o);
        end else begin
          o = blank(b_op); o.adrsrc = 1'b1; o.memw = 1'b1;
          exp_q.push_back(o);
        end
      end
      2'b00: begin
        case (b_funct[4:1])
          4'b0100: begin ctl = 2'd0; known = 1; wr = 1; end
          4'b0010: begin ctl = 2'd1; known = 1; wr = 1; end
          4'b0000: begin ctl = 2'd2; known = 1; wr = 1; end
          4'b1100: begin ctl = 2'd3; known = 1; wr = 1; end
          4'b1010: begin ctl = 2'd1; known = 1; wr = 0; end
          default: begin ctl = 2'd0; known = 0; wr = 0; end
        endcase
        o = blank(b_op);
        o.alusrcb = b_funct[5] ? 2'b01 : 2'b00;
        o.aluctl  = ctl;
        o.flagw   = known ? {b_funct[0], b_funct[0] & (ctl <= 2'd1)} : 2'b00;
        exp_q.push_back(o);
        o = blank(b_op); o.regw = wr; o.pcs = wr && (b_rd == 4'd15);
        exp_q.push_back(o);
      end
      2'b10: begin
        o = blank(b_op); o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.pcs = 1'b1;
        exp_q.push_back(o);
      end
      default: ;
    endcase
  endtask

  task automatic test_reset;
    op = 2'($urandom); funct = 6'($urandom); rd = 4'($urandom);
    rst_a = 1'b1; rst_h = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== reset_v(op))
        $display("FAIL reset cyc%0d got %h expected %h", i, obs_a, reset_v(op));
      else passed++;
      @(posedge clk); #1;
    end
    rst_a = 1'b0;
  endtask

  task automatic test_data_processing;
    logic [5:0] f_tab[7];
    logic [3:0] r_tab[7];
    f_tab = '{6'b001000, 6'b100101, 6'b110101, 6'b011001, 6'b000001, 6'b001110, 6'b101001};
    r_tab = '{4'd1, 4'd3, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15};
    for (int k = 0; k < 7; k++) begin
      op = 2'b00; funct = f_tab[k]; rd = r_tab[k];
      build(op, funct, rd);
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_q[i])
          $display("FAIL dp%0d cyc%0d got %h expected %h", k, i, obs_a, exp_q[i]);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_memory;
    logic [5:0] f_tab[3];
    logic [3:0] r_tab[3];
    f_tab = '{6'b011001, 6'b011001, 6'b011000};
    r_tab = '{4'd15, 4'd2, 4'd15};
    for (int k = 0; k < 3; k++) begin
      op = 2'b01; funct = f_tab[k]; rd = r_tab[k];
      build(op, funct, rd);
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_q[i])
          $display("FAIL mem%0d cyc%0d got %h expected %h", k, i, obs_a, exp_q[i]);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch_and_illegal;
    logic [1:0] o_tab[3];
    o_tab = '{2'b10, 2'b11, 2'b10};
    for (int k = 0; k < 3; k++) begin
      op = o_tab[k]; funct = 6'($urandom); rd = 4'($urandom);
      build(op, funct, rd);
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_q[i])
          $display("FAIL br%0d cyc%0d got %h expected %h", k, i, obs_a, exp_q[i]);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_in_memwr;
    op = 2'b01; funct = 6'b011000; rd = 4'($urandom);
    build(op, funct, rd);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_q[i])
        $display("FAIL str_pre cyc%0d got %h expected %h", i, obs_a, exp_q[i]);
      else passed++;
      @(posedge clk); #1;
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_a !== reset_v(op))
      $display("FAIL str_reset got %h expected %h", obs_a, reset_v(op));
    else passed++;
    @(posedge clk); #1;
    rst_a = 1'b0;
    op = 2'b00; funct = 6'b001000; rd = 4'd4;
    build(op, funct, rd);
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_q[i])
        $display("FAIL str_after cyc%0d got %h expected %h", i, obs_a, exp_q[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_random;
    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom); funct = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      build(op, funct, rd);
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs_a !== exp_q[i])
          $display("FAIL rnd%0d op%b f%b rd%0d cyc%0d got %h expected %h",
                   k, op, funct, rd, i, obs_a, exp_q[i]);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_halt;
    outs_t e;
    rst_a = 1'b1; rst_h = 1'b1;
    op = 2'b11; funct = 6'($urandom); rd = 4'($urandom);
    @(posedge clk); #1;
    rst_h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) op = 2'($urandom);
      e = (i == 0) ? fetch_v(op) : (i == 1) ? decode_v(op) : blank(op);
      if (i >= 2) e.halted = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_h !== e)
        $display("FAIL halt cyc%0d got %h expected %h", i, obs_h, e);
      else passed++;
      @(posedge clk); #1;
    end
    rst_h = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_h !== reset_v(op))
      $display("FAIL halt_reset got %h expected %h", obs_h, reset_v(op));
    else passed++;
    @(posedge clk); #1;
    rst_h = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_h !== fetch_v(op))
      $display("FAIL halt_exit got %h expected %h", obs_h, fetch_v(op));
    else passed++;
  endtask

  initial begin
    test_reset;
    test_data_processing;
    test_memory;
    test_branch_and_illegal;
    test_reset_in_memwr;
    test_back_to_back_random;
    test_halt;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
